cmsdk_irq_gen: RTL

- Interrupt transmitter: converts event pulses in the CLK domain into a glitch-free, registered level IRQOUT for a receiver in another clock domain.
- The receiver synchronizes IRQOUT and treats it as valid only after it is high for two of its own cycles.
- Closes a four-phase handshake using an asynchronous acknowledge ACKIN returned from the receiver domain.
- Counts pending events so each event yields exactly one IRQ handshake.

---
 rtl/cmsdk_irq_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cmsdk_irq_gen.sv
// cmsdk_irq_gen: turns CLK-domain event pulses into a registered, glitch-free
// IRQ level and completes a four-phase handshake with an asynchronous ACKIN.
// Events are counted so each one yields exactly one IRQ handshake.
module cmsdk_irq_gen #(
    parameter int MIN_HIGH = 4,   // minimum IRQOUT high time in CLK cycles, 2..15
    parameter int CNT_W    = 4    // width of the pending-event counter
) (
    input  logic             RSTn,
    input  logic             CLK,
    input  logic             EVENT,
    input  logic             ENABLE,
    input  logic             ACKIN,
    input  logic             CLR_OVF,
    output logic             IRQOUT,
    output logic [CNT_W-1:0] PENDCNT,
    output logic             OVERFLOW,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // Timer saturates here; it is 4 bits wide so it covers MIN_HIGH up to 15.
    localparam logic [3:0]       TMAX    = 4'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [3:0]       timer, timer_nxt;
    logic             evt_prev;
    logic             evt_arm;
    logic             evt_rise;
    logic             ack_s1, ack_s2;
    logic             cnt_dec;
    logic             ovf_set;

    // Pending count update: increment/decrement with saturation at the top.
    // Simultaneous increment and decrement cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                   input logic inc,
                                                   input logic dec);
        if (inc && !dec) begin
            return (c == CNT_MAX) ? c : c + CNT_W'(1);
        end else if (dec && !inc) begin
            return c - CNT_W'(1);
        end else begin
            return c;
        end
    endfunction

    // Overflow occurs when a new event finds the counter full and no slot frees up.
    function automatic logic ovf_detect(input logic [CNT_W-1:0] c,
                                        input logic inc,
                                        input logic dec);
        return inc && !dec && (c == CNT_MAX);
    endfunction

    // A level already high when reset releases is not an edge: evt_arm only
    // opens the detector once EVENT has been sampled low.
    assign evt_rise = EVENT & ~evt_prev & evt_arm;
    assign ovf_set  = ovf_detect(PENDCNT, evt_rise, cnt_dec);

    // Event edge detector registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            evt_prev <= 1'b0;
            evt_arm  <= 1'b0;
        end else begin
            evt_prev <= EVENT;
            if (!EVENT) begin
                evt_arm <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the acknowledge from the receiver domain.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ACKIN;
            ack_s2 <= ack_s1;
        end
    end

    // Handshake next-state logic, high-time timer and counter decrement.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A stale ack from the previous handshake must have dropped first.
                if (ENABLE && (PENDCNT != '0) && !ack_s2) begin
                    state_nxt = ST_ASSERT;
                    timer_nxt = 4'd0;
                end
            end
            ST_ASSERT: begin
                // Ack is only looked at once the minimum high time has elapsed.
                if (timer == TMAX) begin
                    if (ack_s2) begin
                        state_nxt = ST_RELEASE;
                        cnt_dec   = 1'b1;
                    end
                end else begin
                    timer_nxt = timer + 4'd1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s2) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, timer and the flop-driven IRQOUT / BUSY outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= ST_IDLE;
            timer  <= 4'd0;
            IRQOUT <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            IRQOUT <= (state_nxt == ST_ASSERT);
            BUSY   <= (state_nxt != ST_IDLE);
        end
    end

    // Pending-event counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            PENDCNT <= '0;
        end else begin
            PENDCNT <= cnt_next(PENDCNT, evt_rise, cnt_dec);
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            OVERFLOW <= 1'b0;
        end else if (ovf_set) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule
